// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: arbitrates NUM_CH byte-wide requesters onto one SDRAM controller port
// with fixed-priority or round-robin selection, a channel-0 lock and a completion timeout.
module ram_port_arbiter #(
   parameter int NUM_CH  = 2,
   parameter int ADDR_W  = 23,
   parameter int DATA_W  = 8,
   parameter bit RR_MODE = 1'b0,
   parameter int TIMEOUT = 255
) (
   input  logic                      clk_sys,
   input  logic                      reset,
   input  logic [NUM_CH*ADDR_W-1:0]  ch_addr,
   input  logic [NUM_CH*DATA_W-1:0]  ch_din,
   input  logic [NUM_CH-1:0]         ch_we,
   input  logic [NUM_CH-1:0]         ch_rd,
   input  logic                      excl,
   output logic [NUM_CH-1:0]         ch_ack,
   output logic                      ch_err,
   output logic [DATA_W-1:0]         rd_data,
   output logic [ADDR_W-1:0]         ram_addr,
   output logic [DATA_W-1:0]         ram_din,
   output logic                      ram_we,
   output logic                      ram_rd,
   input  logic [DATA_W-1:0]         ram_dout,
   input  logic                      ram_done,
   output logic                      busy,
   output logic [$clog2(NUM_CH)-1:0] grant_id
);
   localparam int GW = $clog2(NUM_CH);
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;
   state_t            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] din_q, din_d, rd_q, rd_d;
   logic              we_q, we_d, err_q, err_d;
   logic [GW-1:0]     gid_q, gid_d, ptr_q, ptr_d, win;
   logic [15:0]       cnt_q, cnt_d;
   logic [NUM_CH-1:0] pending;
   // Scanning in reverse search order lets the last hit be the first candidate in that order.
   function automatic logic [GW-1:0] pick(input logic [NUM_CH-1:0] req, input logic [GW-1:0] ptr);
      logic [GW-1:0] w;
      int idx;
      w = '0;
      for (int k = NUM_CH; k >= 1; k--) begin
         idx = RR_MODE ? (int'(ptr) + k) % NUM_CH : k - 1;
         if (req[idx]) w = GW'(idx);
      end
      return w;
   endfunction
   assign pending = (ch_we | ch_rd) & (excl ? NUM_CH'(1) : {NUM_CH{1'b1}});
   assign win     = pick(pending, ptr_q);
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      din_d   = din_q;
      we_d    = we_q;
      gid_d   = gid_q;
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      err_d   = err_q;
      rd_d    = rd_q;
      unique case (state_q)
         IDLE: if (|pending) begin
            addr_d  = ch_addr[win*ADDR_W +: ADDR_W];
            din_d   = ch_din[win*DATA_W +: DATA_W];
            we_d    = ch_we[win];
            gid_d   = win;
            state_d = ISSUE;
         end
         ISSUE: begin
            cnt_d   = 16'(TIMEOUT);
            state_d = WAIT;
         end
         WAIT: if (ram_done) begin
            rd_d    = we_q ? rd_q : ram_dout;
            state_d = ACK;
         end else begin
            cnt_d   = cnt_q - 16'd1;
            err_d   = cnt_q == 16'd1;
            state_d = cnt_q == 16'd1 ? ACK : WAIT;
         end
         ACK: begin
            err_d   = 1'b0;
            ptr_d   = gid_q;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         addr_q  <= '0;
         din_q   <= '0;
         we_q    <= 1'b0;
         gid_q   <= '0;
         ptr_q   <= GW'(NUM_CH - 1);
         cnt_q   <= '0;
         err_q   <= 1'b0;
         rd_q    <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         din_q   <= din_d;
         we_q    <= we_d;
         gid_q   <= gid_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
         rd_q    <= rd_d;
      end
   end
   assign ram_we   = state_q == ISSUE && we_q;
   assign ram_rd   = state_q == ISSUE && !we_q;
   assign ram_addr = addr_q;
   assign ram_din  = din_q;
   assign ch_ack   = state_q == ACK ? NUM_CH'(1) << gid_q : '0;
   assign ch_err   = state_q == ACK && err_q;
   assign busy     = state_q != IDLE;
   assign grant_id = gid_q;
   assign rd_data  = rd_q;
endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter: directed scoreboard bench for ram_port_arbiter in fixed-priority,
// round-robin and short-timeout configurations.
module tb_ram_port_arbiter;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   n_chk = 0;
   int   n_fail = 0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   typedef struct {
      int          ch;
      bit          we;
      logic [22:0] addr;
      logic [7:0]  din;
      logic [7:0]  rdata;
      int          lat;
   } exp_t;
   typedef struct {
      bit          we;
      logic [22:0] addr;
      logic [7:0]  din;
      int          cyc;
   } strb_t;
   logic [45:0] a_addr = '0;
   logic [15:0] a_din = '0;
   logic [1:0]  a_we = '0, a_rd = '0, a_ack;
   logic        a_excl = 1'b0, a_err, a_rwe, a_rrd, a_done = 1'b0, a_busy;
   logic [7:0]  a_rdd, a_rdin, a_dout_drv = '0, a_dout = '0, a_rd_model = '0;
   logic [22:0] a_raddr;
   logic [0:0]  a_gid;
   int          a_lat = 2;
   exp_t        a_exp[$];
   strb_t       a_sq[$];
   ram_port_arbiter #(.NUM_CH(2), .ADDR_W(23), .DATA_W(8), .RR_MODE(1'b0), .TIMEOUT(255)) u_a (
      .clk_sys(clk), .reset(rst), .ch_addr(a_addr), .ch_din(a_din), .ch_we(a_we), .ch_rd(a_rd),
      .excl(a_excl), .ch_ack(a_ack), .ch_err(a_err), .rd_data(a_rdd), .ram_addr(a_raddr),
      .ram_din(a_rdin), .ram_we(a_rwe), .ram_rd(a_rrd), .ram_dout(a_dout_drv), .ram_done(a_done),
      .busy(a_busy), .grant_id(a_gid));
   logic [68:0] b_addr = {23'h30, 23'h20, 23'h10};
   logic [23:0] b_din = '0;
   logic [2:0]  b_we = '0, b_rd = '0, b_ack;
   logic        b_excl = 1'b0, b_err, b_rwe, b_rrd, b_done = 1'b0, b_busy;
   logic [7:0]  b_rdd, b_rdin, b_dout = '0;
   logic [22:0] b_raddr;
   logic [1:0]  b_gid;
   int          b_exp[$];
   ram_port_arbiter #(.NUM_CH(3), .ADDR_W(23), .DATA_W(8), .RR_MODE(1'b1), .TIMEOUT(255)) u_b (
      .clk_sys(clk), .reset(rst), .ch_addr(b_addr), .ch_din(b_din), .ch_we(b_we), .ch_rd(b_rd),
      .excl(b_excl), .ch_ack(b_ack), .ch_err(b_err), .rd_data(b_rdd), .ram_addr(b_raddr),
      .ram_din(b_rdin), .ram_we(b_rwe), .ram_rd(b_rrd), .ram_dout(b_dout), .ram_done(b_done),
      .busy(b_busy), .grant_id(b_gid));
   logic [45:0] c_addr = '0;
   logic [15:0] c_din = '0;
   logic [1:0]  c_we = '0, c_rd = '0, c_ack;
   logic        c_excl = 1'b0, c_err, c_rwe, c_rrd, c_done = 1'b0, c_busy;
   logic [7:0]  c_rdd, c_rdin, c_dout = 8'hEE;
   logic [22:0] c_raddr;
   logic [0:0]  c_gid;
   ram_port_arbiter #(.NUM_CH(2), .ADDR_W(23), .DATA_W(8), .RR_MODE(1'b0), .TIMEOUT(4)) u_c (
      .clk_sys(clk), .reset(rst), .ch_addr(c_addr), .ch_din(c_din), .ch_we(c_we), .ch_rd(c_rd),
      .excl(c_excl), .ch_ack(c_ack), .ch_err(c_err), .rd_data(c_rdd), .ram_addr(c_raddr),
      .ram_din(c_rdin), .ram_we(c_rwe), .ram_rd(c_rrd), .ram_dout(c_dout), .ram_done(c_done),
      .busy(c_busy), .grant_id(c_gid));
   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   // Controller model for instance A: a_lat cycles from strobe to done, a_lat==0 never answers.
   initial forever begin
      @(negedge clk);
      if (a_rrd || a_rwe) begin
         a_sq.push_back('{a_rwe, a_raddr, a_rdin, cyc});
         if (a_lat != 0) begin
            @(negedge clk);
            check("a_strobe_width", {a_rwe, a_rrd}, 2'b00);
            repeat (a_lat - 1) @(negedge clk);
            a_done = 1'b1;
            a_dout_drv = a_dout;
            @(negedge clk);
            a_done = 1'b0;
         end
      end
   end
   // Controller model for instance B: done one cycle after strobe, data = low address byte.
   initial forever begin
      @(negedge clk);
      if (b_rrd) begin
         @(negedge clk);
         b_done = 1'b1;
         b_dout = b_raddr[7:0];
         @(negedge clk);
         b_done = 1'b0;
      end
   end
   task automatic a_expect(input int ch, input bit we, input logic [22:0] addr, input logic [7:0] din,
                           input logic [7:0] rdata);
      exp_t e;
      e.ch = ch;
      e.we = we;
      e.addr = addr;
      e.din = din;
      e.rdata = rdata;
      e.lat = a_lat;
      a_exp.push_back(e);
   endtask
   task automatic a_req(input int ch, input bit we, input bit rd, input logic [22:0] addr,
                        input logic [7:0] din, input logic [7:0] rdata);
      a_we[ch] = we;
      a_rd[ch] = rd;
      a_addr[ch*23 +: 23] = addr;
      a_din[ch*8 +: 8] = din;
      a_expect(ch, we, addr, din, rdata);
   endtask
   task automatic a_serve();
      exp_t  e;
      strb_t s;
      int    n = 0;
      while (a_ack == 2'b00 && n < 300) begin
         @(negedge clk);
         n++;
      end
      check("a_ack_in_time", 64'(a_ack != 2'b00), 64'd1);
      e = a_exp.pop_front();
      if (!e.we) a_rd_model = e.rdata;
      check("a_ack_onehot", a_ack, 64'(2'b01 << e.ch));
      check("a_err", a_err, 0);
      check("a_grant_id", a_gid, e.ch);
      check("a_rd_data", a_rdd, a_rd_model);
      check("a_strobe_count", a_sq.size(), 1);
      if (a_sq.size() != 0) begin
         s = a_sq.pop_front();
         check("a_op_we", s.we, e.we);
         check("a_ram_addr", s.addr, e.addr);
         if (e.we) check("a_ram_din", s.din, e.din);
         check("a_ack_latency", cyc - s.cyc, e.lat + 1);
      end
      a_we[e.ch] = 1'b0;
      a_rd[e.ch] = 1'b0;
      @(negedge clk);
      check("a_ack_pulse", a_ack, 0);
   endtask
   initial begin
      int    n;
      int    g;
      int    s_cyc;
      @(negedge clk);
      check("rst_a_outs", {a_ack, a_err, a_rdd, a_raddr, a_rdin, a_rwe, a_rrd, a_busy, a_gid}, 0);
      check("rst_b_outs", {b_ack, b_err, b_rdd, b_busy, b_gid}, 0);
      check("rst_c_outs", {c_ack, c_err, c_rdd, c_busy, c_gid}, 0);
      rst = 1'b0;
      a_lat = 3;
      a_dout = 8'h5A;
      a_req(1, 1'b0, 1'b1, 23'h000123, 8'h00, 8'h5A);
      a_serve();
      a_lat = 2;
      a_dout = 8'hC3;
      a_req(0, 1'b1, 1'b0, 23'h000400, 8'h3C, 8'h00);
      a_req(1, 1'b0, 1'b1, 23'h7FFFFF, 8'h00, 8'hC3);
      a_serve();
      a_serve();
      a_req(1, 1'b1, 1'b1, 23'h000222, 8'h77, 8'h00);
      a_serve();
      g = 0;
      repeat (3) begin
         @(negedge clk);
         if (a_busy) g++;
      end
      check("a_single_ack", g, 0);
      a_excl = 1'b1;
      a_rd[1] = 1'b1;
      a_addr[23 +: 23] = 23'h000333;
      a_dout = 8'h66;
      g = 0;
      repeat (100) begin
         @(negedge clk);
         if (a_busy) g++;
      end
      check("a_excl_blocks_ch1", g, 0);
      a_req(0, 1'b1, 1'b0, 23'h000444, 8'h99, 8'h00);
      a_serve();
      a_excl = 1'b0;
      a_expect(1, 1'b0, 23'h000333, 8'h00, 8'h66);
      a_serve();
      b_exp.push_back(0);
      b_exp.push_back(1);
      b_exp.push_back(2);
      b_exp.push_back(0);
      b_rd = 3'b111;
      for (int i = 0; i < 4; i++) begin
         int ch;
         n = 0;
         while (b_ack == 3'b000 && n < 100) begin
            @(negedge clk);
            n++;
         end
         ch = b_exp.pop_front();
         check("b_rr_ack", b_ack, 64'(3'b001 << ch));
         check("b_rr_grant", b_gid, ch);
         check("b_rr_rd_data", b_rdd, (ch + 1) * 16);
         check("b_rr_err", b_err, 0);
         if (i == 3) b_rd = 3'b000;
         @(negedge clk);
      end
      c_rd[1] = 1'b1;
      c_addr[23 +: 23] = 23'h000055;
      n = 0;
      while (!c_rrd && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("c_strobe_addr", {c_rrd, c_raddr}, {1'b1, 23'h000055});
      s_cyc = cyc;
      n = 0;
      while (c_ack == 2'b00 && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("c_timeout_latency", cyc - s_cyc, 5);
      check("c_timeout_ack", c_ack, 2'b10);
      check("c_timeout_err", c_err, 1);
      check("c_timeout_rd_data", c_rdd, 0);
      c_rd[1] = 1'b0;
      @(negedge clk);
      check("c_err_pulse", {c_ack, c_err, c_busy}, 0);
      c_we[0] = 1'b1;
      c_din[7:0] = 8'h11;
      n = 0;
      while (!c_rwe && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("c_write_strobe", {c_rwe, c_rdin}, {1'b1, 8'h11});
      @(negedge clk);
      c_done = 1'b1;
      @(negedge clk);
      c_done = 1'b0;
      check("c_after_err_ack", {c_ack, c_err}, {2'b01, 1'b0});
      c_we[0] = 1'b0;
      a_lat = 0;
      a_rd[0] = 1'b1;
      a_addr[22:0] = 23'h000555;
      n = 0;
      while (!a_rrd && n < 50) begin
         @(negedge clk);
         n++;
      end
      repeat (2) @(negedge clk);
      check("a_busy_in_wait", {a_busy, a_raddr}, {1'b1, 23'h000555});
      #2 rst = 1'b1;
      #1 check("a_async_reset", {a_ack, a_err, a_rdd, a_raddr, a_rdin, a_rwe, a_rrd, a_busy, a_gid}, 0);
      a_rd = '0;
      a_sq.delete();
      a_rd_model = 8'h00;
      @(negedge clk);
      rst = 1'b0;
      a_lat = 2;
      a_req(0, 1'b1, 1'b0, 23'h000010, 8'hAB, 8'h00);
      a_serve();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
